// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared types and constants for the ROM port arbiter.
//               Requester identifiers, address width, word-alignment mask
//               and the access-error predicate used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_e;

  localparam int         ADDR_W          = 32;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // An access is illegal when it is not word aligned or when any address
  // bit at or above the ROM byte-address width is set.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input int                depth);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    out_of_range = (addr >> depth) != '0;
    return misaligned || out_of_range;
  endfunction

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rom_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_rr
// Description : Two-way round-robin picker. Purely combinational.
//               Bit 0 = IF, bit 1 = LS.
// Ports       : i_req    [1:0] eligible requesters
//               i_prio         side favoured under contention
//               o_gnt    [1:0] one-hot (or zero) grant
//               o_prio_d       next pointer: the side not granted, or hold
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arb_rr
  import rom_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_e       i_prio,
  output logic [1:0] o_gnt,
  output req_e       o_prio_d
);

  always_comb begin
    o_gnt    = 2'b00;
    o_prio_d = i_prio;

    if (i_req == 2'b11) begin
      o_gnt = (i_prio == REQ_LS) ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end

    // Any grant hands priority to the other side, so contention alternates
    // strictly and a solo winner yields the next tie to its peer.
    if (o_gnt[0]) begin
      o_prio_d = REQ_LS;
    end else if (o_gnt[1]) begin
      o_prio_d = REQ_IF;
    end
  end

endmodule : rom_arb_rr
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares the combinational instruction-ROM read port between
//               instruction fetch (IF) and load/store constant reads (LS).
//               One grant per cycle, round-robin under contention, registered
//               read data one cycle after grant, misaligned/out-of-range
//               flagging, and an IF flush that blocks grant and masks response.
// Ports       : clk_i, rst_i (async, active-high)
//               if_req_i/if_addr_i/if_flush_i -> if_gnt_o, if_rvalid_o,
//                                                 if_rdata_o, if_err_o
//               ls_req_i/ls_addr_i            -> ls_gnt_o, ls_rvalid_o,
//                                                 ls_rdata_o, ls_err_o
//               rom_addr_o -> ROM, rom_data_i <- ROM (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,

  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ls_err_o,

  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i
);

  req_e        r_prio;
  req_e        w_prio_d;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_if_err;
  logic        w_ls_err;

  logic        r_if_rvalid;
  logic        r_if_err;
  logic [31:0] r_if_rdata;
  logic        r_ls_rvalid;
  logic        r_ls_err;
  logic [31:0] r_ls_rdata;

  // A flushed fetch is simply not a candidate this cycle.
  assign w_req = {ls_req_i, if_req_i & ~if_flush_i};

  rom_arb_rr u_rr (
    .i_req    (w_req),
    .i_prio   (r_prio),
    .o_gnt    (w_gnt),
    .o_prio_d (w_prio_d)
  );

  // Grants are combinational; suppress them while reset is asserted so no
  // access is presented to the ROM or the requesters during reset.
  assign w_if_gnt = w_gnt[0] & ~rst_i;
  assign w_ls_gnt = w_gnt[1] & ~rst_i;
  assign if_gnt_o = w_if_gnt;
  assign ls_gnt_o = w_ls_gnt;

  assign w_if_err = addr_err(if_addr_i, DEPTH);
  assign w_ls_err = addr_err(ls_addr_i, DEPTH);

  // An erroring access still takes the slot but never reaches the ROM.
  always_comb begin
    rom_addr_o = '0;
    if (w_if_gnt && !w_if_err) begin
      rom_addr_o = if_addr_i;
    end else if (w_ls_gnt && !w_ls_err) begin
      rom_addr_o = ls_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio      <= REQ_IF;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_prio      <= w_prio_d;
      r_if_rvalid <= w_if_gnt;
      r_if_err    <= w_if_gnt & w_if_err;
      r_ls_rvalid <= w_ls_gnt;
      r_ls_err    <= w_ls_gnt & w_ls_err;
      // Read data only moves on a grant; otherwise the last value is held.
      if (w_if_gnt) begin
        r_if_rdata <= w_if_err ? '0 : rom_data_i;
      end
      if (w_ls_gnt) begin
        r_ls_rdata <= w_ls_err ? '0 : rom_data_i;
      end
    end
  end

  // A fetch response landing in a flush cycle belongs to the cancelled path.
  assign if_rvalid_o = r_if_rvalid & ~if_flush_i;
  assign if_rdata_o  = r_if_rdata;
  assign if_err_o    = r_if_err;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_rdata_o  = r_ls_rdata;
  assign ls_err_o    = r_ls_err;

endmodule : rom_port_arbiter
`default_nettype wire
